// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the two-port convolution job scheduler.
package conv_sched_pkg;

    localparam int NREQ = 2;

    // Encodings are fixed so downstream debug tooling can decode the raw state bits.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_RESP   = 3'd3;
    localparam logic [2:0] ST_ABORT  = 3'd4;
    localparam logic [2:0] ST_REJECT = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LAUNCH = ST_LAUNCH,
        S_RUN    = ST_RUN,
        S_RESP   = ST_RESP,
        S_ABORT  = ST_ABORT,
        S_REJECT = ST_REJECT
    } sched_state_t;

    // last=1 out of reset so port 0 wins the first contended pick.
    localparam logic LAST_RST  = 1'b1;
    localparam logic SHAPE_RST = 1'b0;

    function automatic logic [NREQ-1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/conv_rr_pick.sv
// Combinational two-way round-robin picker: when both ports request, the one not served last wins.
module conv_rr_pick
    import conv_sched_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic            last,
    output logic            valid,
    output logic            pick
);

    assign valid = |req;
    assign pick  = (&req) ? ~last : req[1];

endmodule

// File: rtl/conv_sched.sv
// Shares one convolution core between two requesters: arbitrates, launches, watches for
// completion or timeout, and returns a one-cycle ack/err to the owning port.
module conv_sched
    import conv_sched_pkg::*;
#(
    parameter int          SIZE_W    = 5,
    parameter int          TIMEOUT_W = 16,
    parameter int unsigned TIMEOUT   = 16'd4095
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req_i,
    input  logic [SIZE_W-1:0] sizeX0_i,
    input  logic [SIZE_W-1:0] sizeY0_i,
    input  logic              shape0_i,
    input  logic [SIZE_W-1:0] sizeX1_i,
    input  logic [SIZE_W-1:0] sizeY1_i,
    input  logic              shape1_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic [NREQ-1:0]   ack_o,
    output logic [NREQ-1:0]   err_o,
    output logic              sel_o,
    output logic              core_start_o,
    output logic [SIZE_W-1:0] core_sizeX_o,
    output logic [SIZE_W-1:0] core_sizeY_o,
    output logic              core_shape_o,
    output logic              core_clr_n_o,
    input  logic              core_busy_i,
    input  logic              core_done_i,
    output logic              busy_o
);

    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT - 1);

    sched_state_t         state;
    logic                 last;
    logic [TIMEOUT_W-1:0] wd;

    logic                 pick_valid;
    logic                 pick;
    logic [SIZE_W-1:0]    pick_x;
    logic [SIZE_W-1:0]    pick_y;
    logic                 pick_shape;
    logic                 size_ok;

    conv_rr_pick u_pick (
        .req   (req_i),
        .last  (last),
        .valid (pick_valid),
        .pick  (pick)
    );

    assign pick_x     = pick ? sizeX1_i : sizeX0_i;
    assign pick_y     = pick ? sizeY1_i : sizeY0_i;
    assign pick_shape = pick ? shape1_i : shape0_i;
    assign size_ok    = (pick_x != '0) && (pick_y != '0);

    assign busy_o = (state != S_IDLE) || core_busy_i;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            last         <= LAST_RST;
            wd           <= '0;
            gnt_o        <= '0;
            ack_o        <= '0;
            err_o        <= '0;
            sel_o        <= 1'b0;
            core_start_o <= 1'b0;
            core_sizeX_o <= '0;
            core_sizeY_o <= '0;
            core_shape_o <= SHAPE_RST;
            core_clr_n_o <= 1'b1;
        end else begin
            // NOTE: pulse outputs get their idle value first; the case below only raises
            // them for the single cycle they are meant to be active.
            core_start_o <= 1'b0;
            ack_o        <= '0;
            err_o        <= '0;
            core_clr_n_o <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        gnt_o <= port_onehot(pick);
                        sel_o <= pick;
                        last  <= pick;
                        if (size_ok) begin
                            core_sizeX_o <= pick_x;
                            core_sizeY_o <= pick_y;
                            core_shape_o <= pick_shape;
                            core_start_o <= 1'b1;
                            state        <= S_LAUNCH;
                        end else begin
                            err_o <= port_onehot(pick);
                            state <= S_REJECT;
                        end
                    end
                end
                S_LAUNCH: begin
                    wd    <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    wd <= wd + 1'b1;
                    // Done has priority over an expiry landing in the same cycle.
                    if (core_done_i) begin
                        ack_o <= port_onehot(sel_o);
                        state <= S_RESP;
                    end else if (wd == WD_LAST) begin
                        err_o        <= port_onehot(sel_o);
                        core_clr_n_o <= 1'b0;
                        state        <= S_ABORT;
                    end
                end
                S_RESP, S_ABORT, S_REJECT: begin
                    gnt_o <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched: a default-timeout instance and a TIMEOUT=8 instance share stimulus.
module tb_conv_sched;

    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rstn;
    logic [1:0]    req;
    logic [SW-1:0] sx0, sy0, sx1, sy1;
    logic          sh0, sh1;
    logic          core_busy, core_done;

    logic [1:0]    gnt, ack, err, t_gnt, t_ack, t_err;
    logic          sel, start, shape, clr_n, busy;
    logic          t_sel, t_start, t_shape, t_clr_n, t_busy;
    logic [SW-1:0] csx, csy, t_csx, t_csy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    conv_sched #(.SIZE_W(SW)) u_dut (
        .clk(clk), .rstn(rstn), .req_i(req),
        .sizeX0_i(sx0), .sizeY0_i(sy0), .shape0_i(sh0),
        .sizeX1_i(sx1), .sizeY1_i(sy1), .shape1_i(sh1),
        .gnt_o(gnt), .ack_o(ack), .err_o(err), .sel_o(sel),
        .core_start_o(start), .core_sizeX_o(csx), .core_sizeY_o(csy),
        .core_shape_o(shape), .core_clr_n_o(clr_n),
        .core_busy_i(core_busy), .core_done_i(core_done), .busy_o(busy)
    );

    conv_sched #(.SIZE_W(SW), .TIMEOUT(8)) u_dut_t8 (
        .clk(clk), .rstn(rstn), .req_i(req),
        .sizeX0_i(sx0), .sizeY0_i(sy0), .shape0_i(sh0),
        .sizeX1_i(sx1), .sizeY1_i(sy1), .shape1_i(sh1),
        .gnt_o(t_gnt), .ack_o(t_ack), .err_o(t_err), .sel_o(t_sel),
        .core_start_o(t_start), .core_sizeX_o(t_csx), .core_sizeY_o(t_csy),
        .core_shape_o(t_shape), .core_clr_n_o(t_clr_n),
        .core_busy_i(core_busy), .core_done_i(core_done), .busy_o(t_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req       = 2'b00;
        core_done = 1'b0;
        rstn      = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    initial begin
        logic [1:0] oh;
        rstn      = 1'b1;
        req       = 2'b00;
        core_busy = 1'b0;
        core_done = 1'b0;
        sx0 = 5'd5; sy0 = 5'd3; sh0 = 1'b1;
        sx1 = 5'd7; sy1 = 5'd2; sh1 = 1'b0;

        // Reset values
        #2 rstn = 1'b0;
        #1;
        check("rst_gnt", gnt, 2'b00);
        check("rst_ack_err", {ack, err}, 4'b0000);
        check("rst_sel_start", {sel, start}, 2'b00);
        check("rst_cfg", {csx, csy, shape}, 11'd0);
        check("rst_clr_n", clr_n, 1'b1);
        check("rst_busy_lo", busy, 1'b0);
        core_busy = 1'b1;
        #1 check("rst_busy_follows", busy, 1'b1);
        core_busy = 1'b0;
        do_reset();

        // Single job on port 0, done at cycle 10
        req = 2'b01;
        step();
        check("a_start_c1", start, 1'b1);
        check("a_cfg_c1", {csx, csy, shape}, {5'd5, 5'd3, 1'b1});
        check("a_gnt_c1", gnt, 2'b01);
        check("a_sel_c1", sel, 1'b0);
        check("a_busy_c1", busy, 1'b1);
        step();
        check("a_start_c2", start, 1'b0);
        for (int c = 3; c <= 10; c++) begin
            step();
            check("a_no_ack_run", ack, 2'b00);
        end
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        check("a_ack_c11", ack, 2'b01);
        check("a_err_c11", err, 2'b00);
        check("a_gnt_c11", gnt, 2'b01);
        step();
        req = 2'b00;
        check("a_ack_c12", ack, 2'b00);
        check("a_gnt_c12", gnt, 2'b00);
        check("a_cfg_hold", {csx, csy, shape}, {5'd5, 5'd3, 1'b1});

        // Both ports requesting: grants alternate, minimum latency ack at cycle 3
        do_reset();
        req = 2'b11;
        for (int j = 0; j < 4; j++) begin
            oh = (j % 2 == 0) ? 2'b01 : 2'b10;
            step();
            req = 2'b11;
            check("b_gnt", gnt, oh);
            check("b_sel", sel, (j % 2));
            check("b_start", start, 1'b1);
            check("b_cfg", {csx, csy, shape},
                  (j % 2 == 0) ? {5'd5, 5'd3, 1'b1} : {5'd7, 5'd2, 1'b0});
            step();
            core_done = 1'b1;
            step();
            core_done = 1'b0;
            check("b_ack", ack, oh);
            step();
            req = ~oh;
            check("b_ack_one_cycle", ack, 2'b00);
        end
        req = 2'b00;

        // Timeout with TIMEOUT=8 on port 1
        do_reset();
        sx1 = 5'd4; sy1 = 5'd4;
        req = 2'b10;
        step();
        check("c_gnt_c1", t_gnt, 2'b10);
        check("c_start_c1", t_start, 1'b1);
        for (int c = 2; c <= 9; c++) begin
            step();
            check("c_run_no_err", {t_err, t_clr_n}, 3'b001);
        end
        step();
        check("c_abort_err", t_err, 2'b10);
        check("c_abort_clr_n", t_clr_n, 1'b0);
        check("c_abort_gnt", t_gnt, 2'b10);
        step();
        req = 2'b00;
        check("c_after_err", t_err, 2'b00);
        check("c_after_clr_n", t_clr_n, 1'b1);
        check("c_after_gnt", t_gnt, 2'b00);
        check("c_after_busy", t_busy, 1'b0);

        // Illegal size on port 0 is rejected without starting the core
        do_reset();
        sx0 = 5'd0;
        req = 2'b01;
        step();
        check("d_err_c1", err, 2'b01);
        check("d_start_c1", start, 1'b0);
        check("d_ack_c1", ack, 2'b00);
        check("d_cfg_untouched", csy, 5'd0);
        step();
        req = 2'b00;
        check("d_err_c2", err, 2'b00);
        check("d_gnt_c2", gnt, 2'b00);
        check("d_start_c2", start, 1'b0);
        sx0 = 5'd5;

        // Done on the exact watchdog-expiry cycle (TIMEOUT=8): done wins
        do_reset();
        req = 2'b01;
        step();
        for (int c = 2; c <= 9; c++) step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        check("e_ack", t_ack, 2'b01);
        check("e_no_err", t_err, 2'b00);
        check("e_clr_n", t_clr_n, 1'b1);
        step();
        req = 2'b00;

        // Asynchronous reset mid-RUN, then contended request goes to port 0
        do_reset();
        req = 2'b10;
        step();
        step();
        step();
        check("f_busy_run", busy, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check("f_rst_gnt", gnt, 2'b00);
        check("f_rst_cfg", {csx, csy, shape}, 11'd0);
        check("f_rst_sel_start", {sel, start}, 2'b00);
        check("f_rst_clr_n", clr_n, 1'b1);
        check("f_rst_busy", busy, 1'b0);
        req = 2'b11;
        @(negedge clk);
        rstn = 1'b1;
        step();
        check("f_gnt_port0", gnt, 2'b01);
        check("f_sel_port0", sel, 1'b0);
        check("f_start", start, 1'b1);
        step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        check("f_ack", ack, 2'b01);
        req = 2'b00;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
